// File: rtl/ram_4port_initiator.sv
// Four-client request initiator for the 1024x8 four-port RAM; same-address writes are arbitrated before issue.
// Latency: accept at edge N -> RAM-side regs in cycle N+1 -> read response pulse in cycle N+2.
// Backpressure: only a write that loses same-address arbitration sees ready low; reads are always ready. Macro: RR_PRIORITY_EN.
module ram_4port_initiator #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_wr,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_wr,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_wr,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [DATA_W-1:0] c_req_wdata,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rsp_rdata,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,

    output logic              cs_a,
    output logic              wr_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] data_in_a,
    input  logic [DATA_W-1:0] data_out_a,

    output logic              cs_b,
    output logic              wr_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_in_b,
    input  logic [DATA_W-1:0] data_out_b,

    output logic              cs_c,
    output logic              wr_c,
    output logic [ADDR_W-1:0] addr_c,
    output logic [DATA_W-1:0] data_in_c,
    input  logic [DATA_W-1:0] data_out_c,

    output logic              cs_d,
    output logic              wr_d,
    output logic [ADDR_W-1:0] addr_d,
    output logic [DATA_W-1:0] data_in_d,
    input  logic [DATA_W-1:0] data_out_d,

    input  logic              conflict,
    output logic              err_conflict
);

    logic [3:0]        req_vld;
    logic [3:0]        req_wr;
    logic [3:0]        wr_vld;
    logic [3:0]        req_rdy;
    logic [3:0]        acc;
    logic [ADDR_W-1:0] req_addr [4];
    logic [DATA_W-1:0] req_wdat [4];
    logic [1:0]        rank     [4];

    logic [3:0]        cs_q;
    logic [3:0]        wr_q;
    logic [ADDR_W-1:0] addr_q   [4];
    logic [DATA_W-1:0] din_q    [4];
    logic [3:0]        rd_pend;
    logic [3:0]        rd_pend_q;
    logic              err_q;

    assign req_vld = {d_req_valid, c_req_valid, b_req_valid, a_req_valid};
    assign req_wr  = {d_req_wr, c_req_wr, b_req_wr, a_req_wr};
    assign req_addr[0] = a_req_addr;
    assign req_addr[1] = b_req_addr;
    assign req_addr[2] = c_req_addr;
    assign req_addr[3] = d_req_addr;
    assign req_wdat[0] = a_req_wdata;
    assign req_wdat[1] = b_req_wdata;
    assign req_wdat[2] = c_req_wdata;
    assign req_wdat[3] = d_req_wdata;

    assign wr_vld = req_vld & req_wr;
    assign acc    = req_vld & req_rdy;

`ifdef RR_PRIORITY_EN
    logic [1:0] ptr;

    // Rank 0 is the winner; the port at ptr holds rank 0 and the rest follow in ring order.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rank[i] = 2'(i) - ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (|(wr_vld & ~req_rdy)) begin
            ptr <= ptr + 2'd1;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rank[i] = 2'(i);
        end
    end
`endif

    // A write yields to any better-ranked write to the same address; reads never yield.
    always_comb begin
        req_rdy = 4'hF;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i != j && wr_vld[i] && wr_vld[j] &&
                    req_addr[i] == req_addr[j] && rank[j] < rank[i]) begin
                    req_rdy[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q      <= '0;
            wr_q      <= '0;
            rd_pend   <= '0;
            rd_pend_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
                din_q[i]  <= '0;
            end
        end else begin
            cs_q      <= acc;
            wr_q      <= acc & req_wr;
            rd_pend   <= acc & ~req_wr;
            rd_pend_q <= rd_pend;
            if (conflict) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    addr_q[i] <= req_addr[i];
                    din_q[i]  <= req_wdat[i];
                end
            end
        end
    end

    assign a_req_ready = req_rdy[0];
    assign b_req_ready = req_rdy[1];
    assign c_req_ready = req_rdy[2];
    assign d_req_ready = req_rdy[3];

    assign a_rsp_valid = rd_pend_q[0];
    assign b_rsp_valid = rd_pend_q[1];
    assign c_rsp_valid = rd_pend_q[2];
    assign d_rsp_valid = rd_pend_q[3];
    assign a_rsp_rdata = data_out_a;
    assign b_rsp_rdata = data_out_b;
    assign c_rsp_rdata = data_out_c;
    assign d_rsp_rdata = data_out_d;

    assign cs_a = cs_q[0];
    assign cs_b = cs_q[1];
    assign cs_c = cs_q[2];
    assign cs_d = cs_q[3];
    assign wr_a = wr_q[0];
    assign wr_b = wr_q[1];
    assign wr_c = wr_q[2];
    assign wr_d = wr_q[3];
    assign addr_a = addr_q[0];
    assign addr_b = addr_q[1];
    assign addr_c = addr_q[2];
    assign addr_d = addr_q[3];
    assign data_in_a = din_q[0];
    assign data_in_b = din_q[1];
    assign data_in_c = din_q[2];
    assign data_in_d = din_q[3];

    assign err_conflict = err_q;

endmodule

// File: tb/tb_ram_4port_initiator.sv
// Directed bench for ram_4port_initiator with a behavioural four-port RAM and a per-port response scoreboard.
module tb_ram_4port_initiator;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inject = 1'b0;
    logic       ram_conflict;
    logic       ram_conflict_seen = 1'b0;
    wire        conflict = ram_conflict | inject;
    wire        err;

    logic [3:0] rv = '0;
    logic [3:0] rw = '0;
    logic [9:0] ra [4];
    logic [7:0] rd [4];
    wire  [3:0] rdy;
    wire  [3:0] rspv;
    wire  [7:0] rspd [4];
    wire  [3:0] cs;
    wire  [3:0] wro;
    wire  [9:0] addr_o [4];
    wire  [7:0] din_o [4];
    logic [7:0] dout [4];
    logic [7:0] mem [1024];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   d_rsp_cnt = 0;
    exp_t sbq [4][$];
    exp_t mon_e;
    logic any_out;

    ram_4port_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(rv[0]), .a_req_ready(rdy[0]), .a_req_wr(rw[0]), .a_req_addr(ra[0]),
        .a_req_wdata(rd[0]), .a_rsp_valid(rspv[0]), .a_rsp_rdata(rspd[0]),
        .b_req_valid(rv[1]), .b_req_ready(rdy[1]), .b_req_wr(rw[1]), .b_req_addr(ra[1]),
        .b_req_wdata(rd[1]), .b_rsp_valid(rspv[1]), .b_rsp_rdata(rspd[1]),
        .c_req_valid(rv[2]), .c_req_ready(rdy[2]), .c_req_wr(rw[2]), .c_req_addr(ra[2]),
        .c_req_wdata(rd[2]), .c_rsp_valid(rspv[2]), .c_rsp_rdata(rspd[2]),
        .d_req_valid(rv[3]), .d_req_ready(rdy[3]), .d_req_wr(rw[3]), .d_req_addr(ra[3]),
        .d_req_wdata(rd[3]), .d_rsp_valid(rspv[3]), .d_rsp_rdata(rspd[3]),
        .cs_a(cs[0]), .wr_a(wro[0]), .addr_a(addr_o[0]), .data_in_a(din_o[0]), .data_out_a(dout[0]),
        .cs_b(cs[1]), .wr_b(wro[1]), .addr_b(addr_o[1]), .data_in_b(din_o[1]), .data_out_b(dout[1]),
        .cs_c(cs[2]), .wr_c(wro[2]), .addr_c(addr_o[2]), .data_in_c(din_o[2]), .data_out_c(dout[2]),
        .cs_d(cs[3]), .wr_d(wro[3]), .addr_d(addr_o[3]), .data_in_d(din_o[3]), .data_out_d(dout[3]),
        .conflict(conflict), .err_conflict(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered reads see pre-write contents; port a wins a write collision.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int p = 0; p < 4; p++) dout[p] = 8'h00;
    end

    always @(posedge clk) begin
        for (int p = 0; p < 4; p++)
            if (cs[2'(p)] && !wro[2'(p)]) dout[p] <= mem[addr_o[p]];
        for (int p = 3; p >= 0; p--)
            if (cs[2'(p)] && wro[2'(p)]) mem[addr_o[p]] <= din_o[p];
    end

    always_comb begin
        ram_conflict = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (cs[2'(i)] && wro[2'(i)] && cs[2'(j)] && wro[2'(j)] && addr_o[i] == addr_o[j])
                    ram_conflict = 1'b1;
    end

    always_comb begin
        any_out = (|cs) | (|wro) | (|rspv) | err;
        for (int p = 0; p < 4; p++) any_out = any_out | (|addr_o[p]) | (|din_o[p]);
    end

    always @(negedge clk) begin
        if (ram_conflict) ram_conflict_seen <= 1'b1;
        if (rspv[3]) d_rsp_cnt <= d_rsp_cnt + 1;
        for (int p = 0; p < 4; p++) begin
            if (rspv[2'(p)]) begin
                vectors++;
                if (sbq[p].size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected port %0d: rsp_valid=1 rdata=%0h at cycle %0d, required no response", p, rspd[p], cyc);
                end else begin
                    mon_e = sbq[p].pop_front();
                    if (rspd[p] !== mon_e.dat || cyc != mon_e.cyc) begin
                        miscompares++;
                        $display("FAIL rsp port %0d: rdata=%0h cycle=%0d, required rdata=%0h cycle=%0d",
                                 p, rspd[p], cyc, mon_e.dat, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic drv(input logic [1:0] p, input logic v, input logic w, input logic [9:0] a, input logic [7:0] d);
        rv[p] = v;
        rw[p] = w;
        ra[p] = a;
        rd[p] = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 4; p++) drv(2'(p), 1'b0, 1'b0, 10'h000, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for a read driven now, accepted at the coming edge.
    task automatic push(input logic [1:0] p, input logic [7:0] d);
        exp_t e;
        e.dat = d;
        e.cyc = cyc + 2;
        sbq[p].push_back(e);
    endtask

    task automatic do_reset();
        idle_all();
        inject = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        idle_all();
        // Reset state; a read is ready during reset but never accepted.
        drv(2'd0, 1'b1, 1'b0, 10'h155, 8'h00);
        #3;
        chk("reset_ready_a_read", 32'(rdy[0]), 32'd1);
        chk("reset_outputs_zero", 32'(any_out), 32'd0);
        do_reset();
        @(negedge clk);
        chk("post_reset_cs_idle", 32'(cs), 32'd0);
        tick();

        // Uncontested write then read.
        drv(2'd0, 1'b1, 1'b1, 10'h3A5, 8'h5C);
        @(negedge clk);
        chk("t1_ready_a_wr", 32'(rdy[0]), 32'd1);
        tick();
        drv(2'd0, 1'b1, 1'b0, 10'h3A5, 8'h00);
        push(2'd0, 8'h5C);
        @(negedge clk);
        chk("t1_cyc2_cs_wr_a", 32'({cs[0], wro[0]}), 32'h3);
        chk("t1_cyc2_addr_a", 32'(addr_o[0]), 32'h3A5);
        chk("t1_cyc2_din_a", 32'(din_o[0]), 32'h5C);
        tick();
        idle_all();
        @(negedge clk);
        chk("t1_cyc3_cs_wr_a", 32'({cs[0], wro[0]}), 32'h2);
        tick();
        @(negedge clk);
        chk("t1_cyc4_cs_a", 32'(cs[0]), 32'd0);
        repeat (2) tick();

        // Three-way same-address write collision.
        do_reset();
        drv(2'd0, 1'b1, 1'b1, 10'h010, 8'h11);
        drv(2'd1, 1'b1, 1'b1, 10'h010, 8'h22);
        drv(2'd2, 1'b1, 1'b1, 10'h010, 8'h33);
        @(negedge clk);
        chk("t2_e1_ready_abc", 32'(rdy[2:0]), 32'b001);
        tick();
        drv(2'd0, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t2_e2_ready_bc", 32'(rdy[2:1]), 32'b01);
        tick();
        drv(2'd1, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t2_e3_ready_c", 32'(rdy[2]), 32'd1);
        tick();
        drv(2'd2, 1'b0, 1'b0, 10'h000, 8'h00);
        repeat (2) tick();
        drv(2'd0, 1'b1, 1'b0, 10'h010, 8'h00);
        push(2'd0, 8'h33);
        tick();
        idle_all();
        repeat (3) tick();
        chk("t2_err_conflict", 32'(err), 32'd0);

        // Different-address writes both accepted, then back-to-back reads on two ports.
        drv(2'd0, 1'b1, 1'b1, 10'h100, 8'hAA);
        drv(2'd1, 1'b1, 1'b1, 10'h101, 8'hBB);
        @(negedge clk);
        chk("t3_ready_ab", 32'(rdy[1:0]), 32'b11);
        tick();
        drv(2'd0, 1'b1, 1'b0, 10'h100, 8'h00);
        drv(2'd1, 1'b1, 1'b0, 10'h101, 8'h00);
        push(2'd0, 8'hAA);
        push(2'd1, 8'hBB);
        tick();
        drv(2'd0, 1'b1, 1'b0, 10'h3A5, 8'h00);
        drv(2'd1, 1'b1, 1'b0, 10'h010, 8'h00);
        push(2'd0, 8'h5C);
        push(2'd1, 8'h33);
        tick();
        idle_all();
        repeat (3) tick();

        // Same-cycle read and write to one address on different ports.
        drv(2'd1, 1'b1, 1'b0, 10'h050, 8'h00);
        drv(2'd2, 1'b1, 1'b1, 10'h050, 8'hFF);
        push(2'd1, 8'h00);
        @(negedge clk);
        chk("t4_ready_bc", 32'(rdy[2:1]), 32'b11);
        tick();
        drv(2'd2, 1'b0, 1'b0, 10'h000, 8'h00);
        push(2'd1, 8'hFF);
        tick();
        idle_all();
        repeat (3) tick();

`ifdef RR_PRIORITY_EN
        // Rotation: a and d contend for 0x200; every edge refuses one of them.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drv(2'd0, 1'b1, 1'b1, 10'h200, 8'(k));
            drv(2'd3, 1'b1, 1'b1, 10'h200, 8'(8'h80 + k));
            @(negedge clk);
            chk("rr_ptr", 32'(dut.ptr), 32'(2'(k)));
            chk("rr_ready_a_d", 32'({rdy[3], rdy[0]}), (k % 4 == 0) ? 32'b01 : 32'b10);
            tick();
        end
        idle_all();
        repeat (2) tick();
`endif

        // Reset mid-operation drops the in-flight read of port d.
        do_reset();
        drv(2'd3, 1'b1, 1'b0, 10'h123, 8'h00);
        tick();
        idle_all();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_outputs_zero_in_reset", 32'(any_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("t5_d_rsp_pulses", 32'(d_rsp_cnt), 32'd0);

        // Injected conflict sets the sticky error one edge later.
        tick();
        inject = 1'b1;
        @(negedge clk);
        chk("t6_err_before_edge", 32'(err), 32'd0);
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("t6_err_after_edge", 32'(err), 32'd1);
        repeat (3) tick();
        chk("t6_err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_reset", 32'(err), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) tick();

        chk("no_ram_conflict", 32'(ram_conflict_seen), 32'd0);
        for (int p = 0; p < 4; p++) chk("sb_drained", 32'(sbq[p].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
